load_queue: RTL and testbench

LOAD_QUEUE -- requirements
Module: load_queue

---
 rtl/load_queue_if.sv | 47 ++++
 rtl/load_queue.sv | 143 ++++++++++++++
 tb/tb_load_queue.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/load_queue_if.sv
// Handshake bundle for the load queue: load allocate, store check, commit,
// flush, violation report and occupancy status.
interface load_queue_if #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [TAG_W-1:0]  ld_tag;
  logic              ld_ready;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [TAG_W-1:0]  st_tag;

  logic              cm_valid;
  logic [TAG_W-1:0]  cm_tag;

  logic              flush_valid;
  logic [TAG_W-1:0]  flush_tag;

  logic              viol_valid;
  logic [TAG_W-1:0]  viol_tag;

  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output ld_valid, ld_addr, ld_tag,
    output st_valid, st_addr, st_tag,
    output cm_valid, cm_tag,
    output flush_valid, flush_tag,
    input  ld_ready, viol_valid, viol_tag, count, full, empty
  );

  modport slave (
    input  ld_valid, ld_addr, ld_tag,
    input  st_valid, st_addr, st_tag,
    input  cm_valid, cm_tag,
    input  flush_valid, flush_tag,
    output ld_ready, viol_valid, viol_tag, count, full, empty
  );
endinterface

// File: rtl/load_queue.sv
// Unordered load queue that tracks executed loads and flags memory-ordering
// violations when an older store resolves to the same word as a younger load.
module load_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 32,
  parameter int OFS_W  = 2
) (
  input logic         clk,
  input logic         reset,
  load_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];

  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              full_q;
  logic              empty_q;
  logic              viol_valid_q;
  logic [TAG_W-1:0]  viol_tag_q;

  logic              alloc_found;
  logic [IDX_W-1:0]  alloc_idx;
  logic              ld_take;
  logic              ld_flushed;
  logic              ld_alloc;

  logic              viol_any;
  logic [TAG_W-1:0]  viol_min;
  logic              viol_hit;

  logic [ADDR_W-OFS_W-1:0] st_word;
  logic [ADDR_W-OFS_W-1:0] ld_word;

  assign st_word = bus.st_addr[ADDR_W-1:OFS_W];
  assign ld_word = bus.ld_addr[ADDR_W-1:OFS_W];

  // Lowest free slot; a slot freed by this cycle's commit is not yet visible here.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
  end

  assign ld_take    = bus.ld_valid && !full_q;
  assign ld_flushed = bus.flush_valid && (bus.ld_tag >= bus.flush_tag);
  assign ld_alloc   = ld_take && !ld_flushed && alloc_found;

  // Oldest younger load hitting the store's word, using pre-commit entry state
  // plus the load arriving this cycle.
  always_comb begin
    viol_any = 1'b0;
    viol_min = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i][ADDR_W-1:OFS_W] == st_word) &&
          (tag_q[i] > bus.st_tag)) begin
        if (!viol_any || (tag_q[i] < viol_min)) begin
          viol_min = tag_q[i];
        end
        viol_any = 1'b1;
      end
    end
    if (ld_take && (ld_word == st_word) && (bus.ld_tag > bus.st_tag)) begin
      if (!viol_any || (bus.ld_tag < viol_min)) begin
        viol_min = bus.ld_tag;
      end
      viol_any = 1'b1;
    end
  end

  assign viol_hit = bus.st_valid && viol_any &&
                    !(bus.flush_valid && (viol_min >= bus.flush_tag));

  // Next valid vector: commit and flush clear, allocation sets a slot that was free.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.cm_valid && valid_q[i] && (tag_q[i] == bus.cm_tag)) begin
        valid_d[i] = 1'b0;
      end
      if (bus.flush_valid && (tag_q[i] >= bus.flush_tag)) begin
        valid_d[i] = 1'b0;
      end
      if (ld_alloc && (alloc_idx == IDX_W'(i))) begin
        valid_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + {{(CNT_W-1){1'b0}}, valid_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      viol_valid_q <= 1'b0;
      viol_tag_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      count_q      <= count_d;
      full_q       <= (count_d == CNT_W'(DEPTH));
      empty_q      <= (count_d == '0);
      viol_valid_q <= viol_hit;
      if (viol_hit) begin
        viol_tag_q <= viol_min;
      end
    end
  end

  // Payload needs no reset: it is only ever read behind a valid bit.
  always_ff @(posedge clk) begin
    if (ld_alloc) begin
      addr_q[alloc_idx] <= bus.ld_addr;
      tag_q[alloc_idx]  <= bus.ld_tag;
    end
  end

  assign bus.ld_ready   = !full_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.viol_valid = viol_valid_q;
  assign bus.viol_tag   = viol_tag_q;

endmodule

// File: tb/tb_load_queue.sv
// Self-checking bench for load_queue: table of per-cycle vectors plus a
// capacity/reset sequence, with expected results queued as each cycle is driven.
module tb_load_queue;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int TAG_W  = 32;

  typedef struct {
    logic        rst;
    logic        ld;
    logic [31:0] la;
    logic [31:0] lt;
    logic        st;
    logic [31:0] sa;
    logic [31:0] stg;
    logic        cm;
    logic [31:0] ct;
    logic        fl;
    logic [31:0] ft;
    logic        ev;
    logic [31:0] etag;
    int          ecount;
  } vec_t;

  typedef struct {
    logic        ev;
    logic [31:0] etag;
    int          ecount;
    int          idx;
  } exp_t;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  int   vecNum;
  vec_t vecs[$];
  exp_t expQ[$];

  load_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) lq ();

  load_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .OFS_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (lq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic rst, input logic ld, input logic [31:0] la,
                              input logic [31:0] lt, input logic st, input logic [31:0] sa,
                              input logic [31:0] stg, input logic cm, input logic [31:0] ct,
                              input logic fl, input logic [31:0] ft, input logic ev,
                              input logic [31:0] etag, input int ecount);
    vec_t v;
    v.rst = rst; v.ld = ld; v.la = la; v.lt = lt; v.st = st; v.sa = sa; v.stg = stg;
    v.cm = cm; v.ct = ct; v.fl = fl; v.ft = ft; v.ev = ev; v.etag = etag; v.ecount = ecount;
    return v;
  endfunction

  task automatic compareBit(input string name, input int idx, input logic act, input logic req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s vec %0d: got %b, expected %b", name, idx, act, req);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard: no expected entry queued");
      return;
    end
    e = expQ.pop_front();
    compareBit("viol_valid", e.idx, lq.viol_valid, e.ev);
    compareBit("full", e.idx, lq.full, (e.ecount == DEPTH));
    compareBit("empty", e.idx, lq.empty, (e.ecount == 0));
    compareBit("ld_ready", e.idx, lq.ld_ready, (e.ecount != DEPTH));
    compared++;
    if (lq.viol_tag !== e.etag) begin
      mismatched++;
      $display("[TB] FAIL viol_tag vec %0d: got %0d, expected %0d", e.idx, lq.viol_tag, e.etag);
    end
    compared++;
    if ($isunknown(lq.count) || int'(lq.count) != e.ecount) begin
      mismatched++;
      $display("[TB] FAIL count vec %0d: got %0d, expected %0d", e.idx, lq.count, e.ecount);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset          = v.rst;
    lq.ld_valid    = v.ld;
    lq.ld_addr     = v.la;
    lq.ld_tag      = v.lt;
    lq.st_valid    = v.st;
    lq.st_addr     = v.sa;
    lq.st_tag      = v.stg;
    lq.cm_valid    = v.cm;
    lq.cm_tag      = v.ct;
    lq.flush_valid = v.fl;
    lq.flush_tag   = v.ft;
    e.ev = v.ev; e.etag = v.etag; e.ecount = v.ecount; e.idx = vecNum;
    expQ.push_back(e);
    vecNum++;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    vecNum = 0;
    reset = 1'b1;
    lq.ld_valid = 1'b0; lq.ld_addr = '0; lq.ld_tag = '0;
    lq.st_valid = 1'b0; lq.st_addr = '0; lq.st_tag = '0;
    lq.cm_valid = 1'b0; lq.cm_tag = '0;
    lq.flush_valid = 1'b0; lq.flush_tag = '0;

    //             rst ld  la         lt  st  sa         stg cm  ct  fl  ft  ev  etag cnt
    vecs.push_back(mk(1, 0, 32'h0,    0,  0, 32'h0,    0,  0,  0,  0,  0,  0,  0,   0));
    vecs.push_back(mk(0, 1, 32'h100,  10, 0, 32'h0,    0,  0,  0,  0,  0,  0,  0,   1));
    vecs.push_back(mk(0, 0, 32'h0,    0,  1, 32'h100,  5,  0,  0,  0,  0,  1,  10,  1));
    vecs.push_back(mk(0, 0, 32'h0,    0,  0, 32'h0,    0,  0,  0,  0,  0,  0,  10,  1));
    vecs.push_back(mk(0, 0, 32'h0,    0,  0, 32'h0,    0,  1,  10, 0,  0,  0,  10,  0));
    vecs.push_back(mk(0, 1, 32'h100,  4,  0, 32'h0,    0,  0,  0,  0,  0,  0,  10,  1));
    vecs.push_back(mk(0, 0, 32'h0,    0,  1, 32'h100,  5,  0,  0,  0,  0,  0,  10,  1));
    vecs.push_back(mk(0, 0, 32'h0,    0,  0, 32'h0,    0,  1,  4,  0,  0,  0,  10,  0));
    vecs.push_back(mk(0, 1, 32'h100,  11, 0, 32'h0,    0,  0,  0,  0,  0,  0,  10,  1));
    vecs.push_back(mk(0, 0, 32'h0,    0,  1, 32'h102,  5,  0,  0,  0,  0,  1,  11,  1));
    vecs.push_back(mk(0, 0, 32'h0,    0,  0, 32'h0,    0,  1,  11, 0,  0,  0,  11,  0));
    vecs.push_back(mk(0, 1, 32'h40,   12, 0, 32'h0,    0,  0,  0,  0,  0,  0,  11,  1));
    vecs.push_back(mk(0, 1, 32'h40,   9,  0, 32'h0,    0,  0,  0,  0,  0,  0,  11,  2));
    vecs.push_back(mk(0, 1, 32'h40,   15, 0, 32'h0,    0,  0,  0,  0,  0,  0,  11,  3));
    vecs.push_back(mk(0, 0, 32'h0,    0,  1, 32'h40,   3,  0,  0,  0,  0,  1,  9,   3));
    vecs.push_back(mk(0, 0, 32'h0,    0,  1, 32'h44,   3,  0,  0,  0,  0,  0,  9,   3));
    vecs.push_back(mk(0, 0, 32'h0,    0,  1, 32'h40,   9,  1,  12, 0,  0,  1,  12,  2));
    vecs.push_back(mk(0, 0, 32'h0,    0,  0, 32'h0,    0,  0,  0,  1,  9,  0,  12,  0));
    vecs.push_back(mk(0, 1, 32'h80,   20, 1, 32'h80,   7,  0,  0,  0,  0,  1,  20,  1));
    vecs.push_back(mk(0, 0, 32'h0,    0,  0, 32'h0,    0,  0,  0,  1,  0,  0,  20,  0));
    vecs.push_back(mk(0, 1, 32'h80,   21, 1, 32'h80,   7,  0,  0,  1,  21, 0,  20,  0));
    vecs.push_back(mk(0, 1, 32'h200,  30, 0, 32'h0,    0,  0,  0,  0,  0,  0,  20,  1));
    vecs.push_back(mk(0, 0, 32'h0,    0,  1, 32'h200,  5,  0,  0,  1,  25, 0,  20,  0));
    vecs.push_back(mk(0, 1, 32'h300,  8,  0, 32'h0,    0,  0,  0,  0,  0,  0,  20,  1));
    vecs.push_back(mk(0, 1, 32'h300,  40, 0, 32'h0,    0,  0,  0,  0,  0,  0,  20,  2));
    vecs.push_back(mk(0, 0, 32'h0,    0,  1, 32'h300,  2,  0,  0,  1,  30, 1,  8,   1));
    vecs.push_back(mk(0, 0, 32'h0,    0,  0, 32'h0,    0,  1,  8,  0,  0,  0,  8,   0));
    vecs.push_back(mk(0, 1, 32'h10,   50, 0, 32'h0,    0,  0,  0,  0,  0,  0,  8,   1));
    vecs.push_back(mk(0, 0, 32'h0,    0,  0, 32'h0,    0,  1,  51, 0,  0,  0,  8,   1));
    vecs.push_back(mk(0, 0, 32'h0,    0,  0, 32'h0,    0,  1,  50, 0,  0,  0,  8,   0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Capacity: fill every slot, then probe the drop and reuse rules.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(mk(0, 1, 32'h400 + 32'(i * 16), 32'(100 + i), 0, 0, 0, 0, 0, 0, 0, 0, 8, i + 1));
    end
    applyStimulus(mk(0, 1, 32'h900, 200, 0, 0,       0, 0, 0,   0, 0, 0, 8,   DEPTH));
    applyStimulus(mk(0, 0, 32'h0,   0,   1, 32'h900, 1, 0, 0,   0, 0, 0, 8,   DEPTH));
    applyStimulus(mk(0, 1, 32'hA00, 201, 0, 0,       0, 1, 100, 0, 0, 0, 8,   DEPTH - 1));
    applyStimulus(mk(0, 0, 32'h0,   0,   1, 32'hA00, 1, 0, 0,   0, 0, 0, 8,   DEPTH - 1));
    applyStimulus(mk(0, 1, 32'hB00, 202, 0, 0,       0, 0, 0,   0, 0, 0, 8,   DEPTH));
    applyStimulus(mk(0, 0, 32'h0,   0,   1, 32'hB00, 1, 0, 0,   0, 0, 1, 202, DEPTH));
    applyStimulus(mk(1, 1, 32'hC00, 300, 1, 32'h410, 1, 0, 0,   0, 0, 0, 0,   0));
    applyStimulus(mk(0, 0, 32'h0,   0,   1, 32'h410, 1, 0, 0,   0, 0, 0, 0,   0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
